// File: rtl/i2c_bus_arbiter.sv
// rtl/i2c_bus_arbiter.sv - idle-gated round-robin arbiter for one shared open-drain I2C pad pair
module i2c_bus_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int IDLE_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic               io_clock,
  input  logic               io_resetn,
  input  logic [NUM_REQ-1:0] io_req,
  output logic [NUM_REQ-1:0] io_grant,
  input  logic [NUM_REQ-1:0] io_req_scl_write,
  input  logic [NUM_REQ-1:0] io_req_sda_write,
  output logic [NUM_REQ-1:0] io_req_scl_read,
  output logic [NUM_REQ-1:0] io_req_sda_read,
  input  logic               io_bus_scl_read,
  input  logic               io_bus_sda_read,
  output logic               io_bus_scl_write,
  output logic               io_bus_sda_write,
  output logic               io_busBusy,
  output logic               io_timeout
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_RELEASE} state_t;

  logic               scl_meta_q, scl_sync_q, sda_meta_q, sda_sync_q, sda_prev_q;
  logic [IW-1:0]      idle_cnt_q, idle_cnt_d;
  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PW-1:0]      ptr_q, ptr_d, owner_q, owner_d, pick, ptr_after_owner;
  logic [TW-1:0]      tcnt_q, tcnt_d;
  logic               busy_q, busy_d, timeout_q, timeout_d;
  logic               found, start_det, stop_det, bus_idle, release_req, timeout_hit;
  int                 k;

  // Two-flop pad synchronizers plus previous SDA for edge detection; all preset to released bus
  always_ff @(posedge io_clock) begin
    if (!io_resetn) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_meta_q <= io_bus_scl_read;
      scl_sync_q <= scl_meta_q;
      sda_meta_q <= io_bus_sda_read;
      sda_sync_q <= sda_meta_q;
      sda_prev_q <= sda_sync_q;
    end
  end

  assign start_det = scl_sync_q & sda_prev_q & ~sda_sync_q;
  assign stop_det  = scl_sync_q & ~sda_prev_q & sda_sync_q;
  assign bus_idle  = (idle_cnt_q == IW'(IDLE_CYCLES));

  // Idle counter: saturating run length of a quiet, non-busy bus
  always_comb begin
    idle_cnt_d = '0;
    if (scl_sync_q && sda_sync_q && !busy_q) begin
      idle_cnt_d = bus_idle ? idle_cnt_q : idle_cnt_q + IW'(1);
    end
  end

  // Round-robin search: first requester at or after ptr, wrapping
  always_comb begin
    found = 1'b0;
    pick  = '0;
    k     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(ptr_q) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!found && io_req[k]) begin
        found = 1'b1;
        pick  = PW'(k);
      end
    end
  end

  assign ptr_after_owner = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + PW'(1);
  assign release_req     = ~io_req[owner_q];
  assign timeout_hit     = ~scl_sync_q && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Next-state logic for the arbitration FSM, busy flag and timeout counter
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    tcnt_d    = '0;
    timeout_d = 1'b0;
    busy_d    = busy_q;
    if (start_det) busy_d = 1'b1;
    else if (stop_det) busy_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus_idle && found) begin
          grant_d = NUM_REQ'(1) << pick;
          owner_d = pick;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        tcnt_d = scl_sync_q ? '0 : tcnt_q + TW'(1);
        if (release_req || timeout_hit) begin
          // A dropped request wins over a coincident timeout: that owner is done, not stuck
          timeout_d = timeout_hit & ~release_req;
          grant_d   = '0;
          ptr_d     = ptr_after_owner;
          tcnt_d    = '0;
          busy_d    = 1'b0;
          state_d   = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (bus_idle) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Arbiter state registers
  always_ff @(posedge io_clock) begin
    if (!io_resetn) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      ptr_q      <= '0;
      owner_q    <= '0;
      tcnt_q     <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      tcnt_q     <= tcnt_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  // Pad drive: only the granted master reaches the pads, and only while in GRANT
  always_comb begin
    io_bus_scl_write = 1'b0;
    io_bus_sda_write = 1'b0;
    if (state_q == ST_GRANT) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        io_bus_scl_write = io_bus_scl_write | (grant_q[i] & io_req_scl_write[i]);
        io_bus_sda_write = io_bus_sda_write | (grant_q[i] & io_req_sda_write[i]);
      end
    end
  end

  assign io_grant        = grant_q;
  assign io_busBusy      = busy_q;
  assign io_timeout      = timeout_q;
  assign io_req_scl_read = {NUM_REQ{scl_sync_q}};
  assign io_req_sda_read = {NUM_REQ{sda_sync_q}};

endmodule
